// File: rtl/tile_pkg.sv
// Shared tile-map definitions: geometry, command opcodes, FSM state codes and lane helpers.
// Used by the tile-map writer, the pixel generator and the grid controller.
package tile_pkg;

  localparam int N_PER_ROW     = 60;
  localparam int N_PER_COL     = 34;
  localparam int TILES_PER_REG = 4;
  localparam int SPRITE_W      = 8;
  localparam int ADDR_W        = 9;
  localparam int WORD_W        = TILES_PER_REG * SPRITE_W;
  localparam int WORDS         = N_PER_ROW * N_PER_COL / TILES_PER_REG;
  localparam int COORD_W       = 6;
  localparam int LANE_W        = $clog2(TILES_PER_REG);
  localparam int TILE_IDX_W    = ADDR_W + LANE_W;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_MOD  = 3'd3;
  localparam logic [2:0] ST_FILL = 3'd4;

  typedef struct packed {
    logic [1:0]          op;
    logic [ADDR_W-1:0]   word;
    logic [LANE_W-1:0]   lane;
    logic [SPRITE_W-1:0] sprite;
  } cmd_t;

  // Row-major tile number; the low bits pick the byte lane, the rest the word.
  function automatic logic [TILE_IDX_W-1:0] tile_index(input logic [COORD_W-1:0] row,
                                                       input logic [COORD_W-1:0] col);
    return TILE_IDX_W'(row) * TILE_IDX_W'(N_PER_ROW) + TILE_IDX_W'(col);
  endfunction

  function automatic logic [SPRITE_W-1:0] get_lane(input logic [WORD_W-1:0] word,
                                                   input logic [LANE_W-1:0] lane);
    return word[int'(lane)*SPRITE_W +: SPRITE_W];
  endfunction

  function automatic logic [WORD_W-1:0] set_lane(input logic [WORD_W-1:0] word,
                                                 input logic [LANE_W-1:0] lane,
                                                 input logic [SPRITE_W-1:0] val);
    logic [WORD_W-1:0] w;
    w = word;
    w[int'(lane)*SPRITE_W +: SPRITE_W] = val;
    return w;
  endfunction

endpackage

// File: rtl/tile_map_writer_if.sv
// Command/response handshake plus the pixel read port of the tile-map writer.
// master = game/grid + pixel side, slave = the tile-map writer.
interface tile_map_writer_if;
  import tile_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [COORD_W-1:0]  cmd_col;
  logic [COORD_W-1:0]  cmd_row;
  logic [SPRITE_W-1:0] cmd_sprite;
  logic                rsp_valid;
  logic [SPRITE_W-1:0] rsp_sprite;
  logic                rsp_err;
  logic                busy;
  logic [ADDR_W-1:0]   pix_tile;
  logic [WORD_W-1:0]   sprite_addr;

  modport master (
    output cmd_valid, cmd_op, cmd_col, cmd_row, cmd_sprite, pix_tile,
    input  cmd_ready, rsp_valid, rsp_sprite, rsp_err, busy, sprite_addr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_col, cmd_row, cmd_sprite, pix_tile,
    output cmd_ready, rsp_valid, rsp_sprite, rsp_err, busy, sprite_addr
  );

endinterface

// File: rtl/tile_ram_dp.sv
// 510x32 dual-port RAM: port A registered read-only (out-of-range reads 0), port B read/write.
// Both ports have one-cycle read latency and are read-first on collision; never stalls.
module tile_ram_dp
  import tile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [WORD_W-1:0] a_dat,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic [WORD_W-1:0] b_wdat,
  output logic [WORD_W-1:0] b_rdat
);

  logic [WORD_W-1:0] mem [WORDS];
  logic [WORD_W-1:0] a_dat_d, a_dat_q;
  logic [WORD_W-1:0] b_rdat_d, b_rdat_q;

  always_comb begin
    a_dat_d = '0;
    if (a_addr <= LAST_WORD) begin
      a_dat_d = mem[a_addr];
    end
    b_rdat_d = mem[b_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_dat_q  <= '0;
      b_rdat_q <= '0;
    end else begin
      a_dat_q  <= a_dat_d;
      b_rdat_q <= b_rdat_d;
    end
  end

  // Array kept out of the reset block so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (b_we) begin
      mem[b_addr] <= b_wdat;
    end
  end

  assign a_dat  = a_dat_q;
  assign b_rdat = b_rdat_q;

endmodule

// File: rtl/tile_map_writer.sv
// Tile-map owner: clears on reset, then serves write/read (3 cycles) and fill (510 cycles) commands.
// cmd_ready is high only in IDLE; the pixel port reads every cycle with one-cycle latency, never stalled.
module tile_map_writer
  import tile_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  tile_map_writer_if.slave bus
);

  logic [2:0]          state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  cmd_t                cmd_q, cmd_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [SPRITE_W-1:0] rsp_sprite_q, rsp_sprite_d;
  logic                rsp_err_q, rsp_err_d;

  logic [ADDR_W-1:0]     b_addr;
  logic                  b_we;
  logic [WORD_W-1:0]     b_wdat;
  logic [WORD_W-1:0]     b_rdat;
  logic [WORD_W-1:0]     a_dat;
  logic [TILE_IDX_W-1:0] tile_idx;
  logic                  cmd_bad;
  logic                  in_idle;

  assign tile_idx = tile_index(bus.cmd_row, bus.cmd_col);
  assign cmd_bad  = (bus.cmd_col >= COORD_W'(N_PER_ROW)) ||
                    (bus.cmd_row >= COORD_W'(N_PER_COL)) ||
                    (bus.cmd_op == OP_RSVD);
  assign in_idle  = (state_q == ST_IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    rsp_valid_d  = 1'b0;
    rsp_sprite_d = rsp_sprite_q;
    rsp_err_d    = rsp_err_q;
    b_addr       = cnt_q;
    b_we         = 1'b0;
    b_wdat       = '0;

    case (state_q)
      ST_INIT: begin
        b_we  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d.op     = bus.cmd_op;
          cmd_d.word   = tile_idx[TILE_IDX_W-1:LANE_W];
          cmd_d.lane   = tile_idx[LANE_W-1:0];
          cmd_d.sprite = bus.cmd_sprite;
          // Rejected commands are answered from IDLE so errors stream at full rate.
          if (cmd_bad) begin
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_sprite_d = '0;
          end else if (bus.cmd_op == OP_FILL) begin
            cnt_d   = '0;
            state_d = ST_FILL;
          end else begin
            state_d = ST_RD;
          end
        end
      end

      ST_RD: begin
        b_addr  = cmd_q.word;
        state_d = ST_MOD;
      end

      ST_MOD: begin
        b_addr       = cmd_q.word;
        rsp_valid_d  = 1'b1;
        rsp_err_d    = 1'b0;
        rsp_sprite_d = '0;
        if (cmd_q.op == OP_WRITE) begin
          b_we   = 1'b1;
          b_wdat = set_lane(b_rdat, cmd_q.lane, cmd_q.sprite);
        end else begin
          rsp_sprite_d = get_lane(b_rdat, cmd_q.lane);
        end
        state_d = ST_IDLE;
      end

      ST_FILL: begin
        b_we   = 1'b1;
        b_wdat = {TILES_PER_REG{cmd_q.sprite}};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) begin
          cnt_d        = '0;
          state_d      = ST_IDLE;
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b0;
          rsp_sprite_d = '0;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_INIT;
      end
    endcase

    // An aborting reset must not leave a stray write behind.
    if (rst) begin
      b_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      cmd_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_sprite_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_sprite_q <= rsp_sprite_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  tile_ram_dp u_ram (
    .clk    (clk),
    .rst    (rst),
    .a_addr (bus.pix_tile),
    .a_dat  (a_dat),
    .b_addr (b_addr),
    .b_we   (b_we),
    .b_wdat (b_wdat),
    .b_rdat (b_rdat)
  );

  assign bus.sprite_addr = a_dat;
  assign bus.cmd_ready   = in_idle;
  assign bus.busy        = !in_idle;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_sprite  = rsp_sprite_q;
  assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_tile_map_writer.sv
// Randomized bench for tile_map_writer against a per-tile byte-array model.
module tb_tile_map_writer;
  import tile_pkg::*;

  localparam int NTILES = N_PER_ROW * N_PER_COL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_map_writer_if bus ();

  tile_map_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] tiles [NTILES];

  // Inputs and outputs are both handled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] model_word(input int w);
    if (w >= NTILES / 4) return 32'h0;
    return {tiles[4*w+3], tiles[4*w+2], tiles[4*w+1], tiles[4*w]};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NTILES; i++) tiles[i] = 8'h00;
  endfunction

  // Applies a command to the model and returns the response it should produce.
  function automatic void model_cmd(input int op, input int col, input int row, input int spr,
                                    output int e_edges, output logic e_err,
                                    output logic [7:0] e_spr);
    e_err   = (col >= N_PER_ROW || row >= N_PER_COL || op == 3);
    e_spr   = 8'h00;
    e_edges = 1;
    if (e_err) return;
    if (op == 0) begin
      tiles[row*N_PER_ROW+col] = 8'(spr);
      e_edges = 3;
    end else if (op == 2) begin
      e_spr   = tiles[row*N_PER_ROW+col];
      e_edges = 3;
    end else begin
      for (int i = 0; i < NTILES; i++) tiles[i] = 8'(spr);
      e_edges = NTILES / 4 + 1;
    end
  endfunction

  task automatic drive_cmd(input int op, input int col, input int row, input int spr);
    bus.cmd_op     = 2'(op);
    bus.cmd_col    = 6'(col);
    bus.cmd_row    = 6'(row);
    bus.cmd_sprite = 8'(spr);
  endtask

  // Issues one command; edges counts clock edges from the accept edge (inclusive) to rsp_valid.
  task automatic do_cmd(input int op, input int col, input int row, input int spr,
                        output int edges, output int ready_low, output logic err,
                        output logic [7:0] rspr, output logic pulse_ok);
    int g;
    drive_cmd(op, col, row, spr);
    bus.cmd_valid = 1'b1;
    g = 0;
    while (bus.cmd_ready !== 1'b1 && g < 2000) begin
      tick();
      g++;
    end
    tick();
    bus.cmd_valid = 1'b0;
    edges     = 1;
    ready_low = 0;
    while (bus.rsp_valid !== 1'b1 && edges < 2000) begin
      if (bus.cmd_ready !== 1'b1) ready_low++;
      tick();
      edges++;
    end
    err  = bus.rsp_err;
    rspr = bus.rsp_sprite;
    tick();
    pulse_ok = (bus.rsp_valid === 1'b0) && (bus.rsp_err === err) && (bus.rsp_sprite === rspr);
  endtask

  task automatic sweep(input string tag);
    for (int w = 0; w < 512; w++) begin
      bus.pix_tile = 9'(w);
      tick();
      n_checks++;
      if (bus.sprite_addr !== model_word(w)) begin
        n_fail++;
        $display("FAIL %s word %0d: got %h expected %h", tag, w, bus.sprite_addr, model_word(w));
      end
    end
  endtask

  task automatic test_reset();
    int n, pulses;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    drive_cmd(0, 0, 0, 0);
    bus.pix_tile = '0;
    repeat (3) tick();
    n_checks++;
    if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b busy=%b rsp_valid=%b expected 0 1 0",
               bus.cmd_ready, bus.busy, bus.rsp_valid);
    end
    n_checks++;
    if (bus.rsp_sprite !== 8'h00 || bus.rsp_err !== 1'b0 || bus.sprite_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: rsp_sprite=%h rsp_err=%b sprite_addr=%h expected zeros",
               bus.rsp_sprite, bus.rsp_err, bus.sprite_addr);
    end
    rst = 1'b0;
    n = 0;
    pulses = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      if (bus.rsp_valid === 1'b1) pulses++;
      n++;
      tick();
    end
    n_checks++;
    if (n != 510 || bus.cmd_ready !== 1'b1 || pulses != 0) begin
      n_fail++;
      $display("FAIL init_time: busy cycles %0d ready=%b pulses %0d expected 510 1 0",
               n, bus.cmd_ready, pulses);
    end
    model_clear();
  endtask

  task automatic test_write_basic();
    int edges, rl, ee;
    logic err, ok, e_err;
    logic [7:0] rs, e_spr;
    do_cmd(0, 5, 0, 8'h2A, edges, rl, err, rs, ok);
    model_cmd(0, 5, 0, 8'h2A, ee, e_err, e_spr);
    n_checks++;
    if (edges != ee || err !== e_err || rs !== e_spr) begin
      n_fail++;
      $display("FAIL write_rsp: edges %0d err %b spr %h expected %0d %b %h", edges, err, rs, ee, e_err, e_spr);
    end
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL write_pulse: rsp_valid not a single held pulse (ok=%b expected 1)", ok);
    end
    bus.pix_tile = 9'd1;
    tick();
    n_checks++;
    if (bus.sprite_addr !== 32'h00002A00) begin
      n_fail++;
      $display("FAIL write_word1: got %h expected 00002a00", bus.sprite_addr);
    end
  endtask

  task automatic test_lanes();
    int edges, rl, ee;
    logic err, ok, e_err;
    logic [7:0] rs, e_spr;
    do_cmd(0, 0, 1, 8'h11, edges, rl, err, rs, ok);
    model_cmd(0, 0, 1, 8'h11, ee, e_err, e_spr);
    do_cmd(0, 3, 1, 8'h44, edges, rl, err, rs, ok);
    model_cmd(0, 3, 1, 8'h44, ee, e_err, e_spr);
    bus.pix_tile = 9'd15;
    tick();
    n_checks++;
    if (bus.sprite_addr !== 32'h44000011) begin
      n_fail++;
      $display("FAIL lanes_word15: got %h expected 44000011", bus.sprite_addr);
    end
    do_cmd(2, 3, 1, 8'hFF, edges, rl, err, rs, ok);
    model_cmd(2, 3, 1, 8'hFF, ee, e_err, e_spr);
    n_checks++;
    if (rs !== 8'h44 || rs !== e_spr || err !== 1'b0 || edges != ee) begin
      n_fail++;
      $display("FAIL lanes_read: spr %h err %b edges %0d expected 44 0 %0d", rs, err, edges, ee);
    end
  endtask

  task automatic test_errors();
    int edges, rl, ee;
    logic err, ok, e_err;
    logic [7:0] rs, e_spr;
    int bad_ops [3] = '{0, 3, 2};
    int bad_col [3] = '{60, 4, 10};
    int bad_row [3] = '{2, 4, 34};
    for (int i = 0; i < 3; i++) begin
      do_cmd(bad_ops[i], bad_col[i], bad_row[i], 8'h99, edges, rl, err, rs, ok);
      model_cmd(bad_ops[i], bad_col[i], bad_row[i], 8'h99, ee, e_err, e_spr);
      n_checks++;
      if (err !== 1'b1 || err !== e_err || rs !== 8'h00 || edges != ee || ok !== 1'b1) begin
        n_fail++;
        $display("FAIL err_cmd%0d: err %b spr %h edges %0d ok %b expected 1 00 %0d 1",
                 i, err, rs, edges, ok, ee);
      end
    end
    bus.cmd_valid = 1'b1;
    drive_cmd(0, 61, 0, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL err_stream%0d: rsp_valid %b err %b ready %b expected 1 1 1",
                 i, bus.rsp_valid, bus.rsp_err, bus.cmd_ready);
      end
    end
    bus.cmd_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_stream_end: rsp_valid %b expected 0", bus.rsp_valid);
    end
    sweep("err_sweep");
  endtask

  task automatic test_random();
    int edges, rl, ee, op, col, row, spr, r;
    logic err, ok, e_err;
    logic [7:0] rs, e_spr;
    for (int i = 0; i < 40; i++) begin
      r   = $urandom_range(0, 9);
      col = $urandom_range(0, N_PER_ROW - 1);
      row = $urandom_range(0, N_PER_COL - 1);
      spr = $urandom_range(0, 255);
      op  = (r < 4) ? 0 : (r < 8) ? 2 : (r == 8) ? 0 : 3;
      if (r == 8) col = $urandom_range(N_PER_ROW, 63);
      do_cmd(op, col, row, spr, edges, rl, err, rs, ok);
      model_cmd(op, col, row, spr, ee, e_err, e_spr);
      n_checks++;
      if (edges != ee || err !== e_err || rs !== e_spr || ok !== 1'b1) begin
        n_fail++;
        $display("FAIL rand%0d op%0d c%0d r%0d: edges %0d err %b spr %h ok %b expected %0d %b %h 1",
                 i, op, col, row, edges, err, rs, ok, ee, e_err, e_spr);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k, cyc, ee;
    int acc [3];
    int cc [3], rr [3], ss [3];
    logic acc_now, e_err;
    logic [7:0] e_spr;
    for (int i = 0; i < 3; i++) begin
      cc[i] = $urandom_range(0, N_PER_ROW - 1);
      rr[i] = $urandom_range(0, N_PER_COL - 1);
      ss[i] = $urandom_range(0, 255);
    end
    k = 0;
    cyc = 0;
    drive_cmd(0, cc[0], rr[0], ss[0]);
    bus.cmd_valid = 1'b1;
    while (k < 3 && cyc < 100) begin
      acc_now = (bus.cmd_ready === 1'b1);
      tick();
      cyc++;
      if (acc_now) begin
        acc[k] = cyc;
        model_cmd(0, cc[k], rr[k], ss[k], ee, e_err, e_spr);
        k++;
        if (k < 3) drive_cmd(0, cc[k], rr[k], ss[k]);
        else bus.cmd_valid = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (k != 3 || acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
      n_fail++;
      $display("FAIL b2b_spacing: accepted %0d gaps %0d %0d expected 3 3 3",
               k, acc[1] - acc[0], acc[2] - acc[1]);
    end
    repeat (3) tick();
    sweep("b2b_sweep");
  endtask

  task automatic test_fill();
    int edges, ready_low, ee, hold_w;
    logic e_err;
    logic [7:0] e_spr;
    logic [31:0] old_w;
    hold_w = 15;
    old_w  = model_word(hold_w);
    bus.pix_tile = 9'(hold_w);
    drive_cmd(1, 0, 0, 8'h07);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    edges = 1;
    ready_low = 0;
    while (bus.rsp_valid !== 1'b1 && edges < 2000) begin
      if (bus.cmd_ready !== 1'b1) ready_low++;
      if (edges == hold_w + 2) begin
        n_checks++;
        if (bus.sprite_addr !== old_w) begin
          n_fail++;
          $display("FAIL fill_collision_old: got %h expected %h", bus.sprite_addr, old_w);
        end
      end
      if (edges == hold_w + 3) begin
        n_checks++;
        if (bus.sprite_addr !== 32'h07070707) begin
          n_fail++;
          $display("FAIL fill_collision_new: got %h expected 07070707", bus.sprite_addr);
        end
      end
      // A command presented while busy must be ignored.
      if (edges == 300) begin
        drive_cmd(0, 1, 1, 8'hEE);
        bus.cmd_valid = 1'b1;
      end
      if (edges == 305) bus.cmd_valid = 1'b0;
      tick();
      edges++;
    end
    model_cmd(1, 0, 0, 8'h07, ee, e_err, e_spr);
    n_checks++;
    if (ready_low != 510 || edges != ee || bus.rsp_err !== e_err || bus.rsp_sprite !== e_spr) begin
      n_fail++;
      $display("FAIL fill_rsp: ready_low %0d edges %0d err %b spr %h expected 510 %0d %b %h",
               ready_low, edges, bus.rsp_err, bus.rsp_sprite, ee, e_err, e_spr);
    end
    tick();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_end: rsp_valid %b ready %b expected 0 1", bus.rsp_valid, bus.cmd_ready);
    end
    sweep("fill_sweep");
  endtask

  task automatic test_reset_mid_fill();
    int edges, n, pulses;
    drive_cmd(1, 0, 0, 8'h55);
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    edges = 1;
    pulses = 0;
    while (edges < 201) begin
      if (bus.rsp_valid === 1'b1) pulses++;
      tick();
      edges++;
    end
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      if (bus.rsp_valid === 1'b1) pulses++;
      n++;
      tick();
    end
    if (bus.rsp_valid === 1'b1) pulses++;
    model_clear();
    n_checks++;
    if (n != 510 || pulses != 0) begin
      n_fail++;
      $display("FAIL abort_fill: busy cycles %0d pulses %0d expected 510 0", n, pulses);
    end
    sweep("abort_sweep");
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "time limit reached");
  end

  initial begin
    test_reset();
    sweep("init_sweep");
    test_write_basic();
    test_lanes();
    test_errors();
    test_random();
    test_back_to_back();
    test_fill();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
